demux_1x2_stream: RTL and testbench

//   Packet-aware 1-to-2 stream demultiplexer, the inverse of mux_2x1.

---
 rtl/demux_1x2_stream.sv | 120 ++++++++++++
 tb/tb_demux_1x2_stream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream: packet-aware 1-to-2 valid/ready stream demultiplexer.
// The route select s is sampled on the first beat of a packet and held
// until the last beat. Each output is a one-entry register slot, so the
// outK_* outputs are registered. in_ready is combinational from the target
// slot's occupancy and the target consumer's ready signal.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s                        route select (0 -> out0, 1 -> out1), sampled at packet start
//   in_data/valid/last       input stream beat
//   in_ready                 input beat accepted this cycle
//   outK_data/valid/last     registered output slot K
//   outK_ready               consumer K accepts the slot contents
//   pkt_cnt0/1               packets fully delivered per output (wrapping)
module demux_1x2_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t state;
  logic   sel_q;

  logic target_c;
  logic in_fire_c;
  logic out0_fire_c;
  logic out1_fire_c;
  logic load0_c;
  logic load1_c;

  // Live select while idle, latched select for the rest of a packet.
  assign target_c = (state == IDLE) ? s : sel_q;

  // Only the target slot gates the input; the other slot never back-pressures.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (target_c) in_ready = !out1_valid || out1_ready;
      else          in_ready = !out0_valid || out0_ready;
    end
  end

  assign in_fire_c   = in_valid && in_ready;
  assign out0_fire_c = out0_valid && out0_ready;
  assign out1_fire_c = out1_valid && out1_ready;
  assign load0_c     = in_fire_c && !target_c;
  assign load1_c     = in_fire_c &&  target_c;

  // Packet framing FSM: remembers the route from the first beat to the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= 1'b0;
    end else if (in_fire_c) begin
      sel_q <= target_c;
      state <= in_last ? IDLE : PKT;
    end
  end

  // Output slot 0: a load wins over a drain so back-to-back beats keep valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
      out0_last  <= 1'b0;
    end else if (load0_c) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
      out0_last  <= in_last;
    end else if (out0_fire_c) begin
      out0_valid <= 1'b0;
    end
  end

  // Output slot 1, same behaviour as slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
      out1_last  <= 1'b0;
    end else if (load1_c) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
      out1_last  <= in_last;
    end else if (out1_fire_c) begin
      out1_valid <= 1'b0;
    end
  end

  // Delivered-packet counters, bumped when a last beat leaves a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (out0_fire_c && out0_last) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (out1_fire_c && out1_last) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Testbench for demux_1x2_stream: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the two outputs.
module tb_demux_1x2_stream;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             s;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_last;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_last;
  logic             out1_ready;
  logic [CNT_W-1:0] pkt_cnt0;
  logic [CNT_W-1:0] pkt_cnt1;

  demux_1x2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s(s),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_last(out0_last), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last), .out1_ready(out1_ready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each output is a FIFO of beats {last,data} still owed to that consumer.
  logic [WIDTH:0]   q0[$];
  logic [WIDTH:0]   q1[$];
  logic [CNT_W-1:0] m_cnt0 = '0;
  logic [CNT_W-1:0] m_cnt1 = '0;
  bit               m_inpkt = 1'b0;
  bit               m_route = 1'b0;

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    bit tgt;
    bit exp_rdy;
    tgt     = m_inpkt ? m_route : s;
    exp_rdy = !rst && (tgt ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) begin
      chk("out0_data", 32'(out0_data), 32'(q0[0][WIDTH-1:0]));
      chk("out0_last", 32'(out0_last), 32'(q0[0][WIDTH]));
    end
    if (q1.size() != 0) begin
      chk("out1_data", 32'(out1_data), 32'(q1[0][WIDTH-1:0]));
      chk("out1_last", 32'(out1_last), 32'(q1[0][WIDTH]));
    end
    chk("pkt_cnt0", 32'(pkt_cnt0), 32'(m_cnt0));
    chk("pkt_cnt1", 32'(pkt_cnt1), 32'(m_cnt1));
    if (rst) begin
      q0.delete();
      q1.delete();
      m_cnt0  = '0;
      m_cnt1  = '0;
      m_inpkt = 1'b0;
      m_route = 1'b0;
    end else begin
      if (q0.size() != 0 && out0_ready) begin
        if (q0[0][WIDTH]) m_cnt0 = m_cnt0 + 1'b1;
        void'(q0.pop_front());
      end
      if (q1.size() != 0 && out1_ready) begin
        if (q1[0][WIDTH]) m_cnt1 = m_cnt1 + 1'b1;
        void'(q1.pop_front());
      end
      if (in_valid && exp_rdy) begin
        if (tgt) q1.push_back({in_last, in_data});
        else     q0.push_back({in_last, in_data});
        m_route = tgt;
        m_inpkt = !in_last;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit sel);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    s        = sel;
  endtask

  logic [WIDTH-1:0] beats[4];

  initial begin
    rst = 1'b1; out0_ready = 1'b0; out1_ready = 1'b0;
    drive(1'b1, 8'h11, 1'b0, 1'b0);

    // Reset held two cycles with in_valid high.
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_cnt0", 32'(pkt_cnt0), 32'd0);
    chk("rst_cnt1", 32'(pkt_cnt1), 32'd0);
    rst = 1'b0;

    // Single-beat packet to out1.
    out1_ready = 1'b1;
    drive(1'b1, 8'hA5, 1'b1, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("single_valid1", 32'(out1_valid), 32'd1);
    chk("single_data1", 32'(out1_data), 32'hA5);
    chk("single_last1", 32'(out1_last), 32'd1);
    chk("single_valid0", 32'(out0_valid), 32'd0);
    step();
    chk("single_cnt1", 32'(pkt_cnt1), 32'd1);

    // Select locked for a 4-beat packet while s toggles.
    out0_ready = 1'b1;
    beats[0] = 8'h10; beats[1] = 8'h21; beats[2] = 8'h32; beats[3] = 8'h43;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, beats[i], i == 3, i[0]);
      step();
      chk("lock_valid0", 32'(out0_valid), 32'd1);
      chk("lock_data0", 32'(out0_data), 32'(beats[i]));
      chk("lock_valid1", 32'(out1_valid), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("lock_cnt0", 32'(pkt_cnt0), 32'd1);
    // Back in IDLE: live s=1 now routes to out1.
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    step();
    chk("idle_after_lock", 32'(out1_data), 32'h5A);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();

    // Back-pressure on out0 during a 3-beat packet.
    out0_ready = 1'b0;
    drive(1'b1, 8'hC0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hC1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(out0_data), 32'hC0);
      step();
    end
    out0_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    step();
    chk("bp_beat2", 32'(out0_data), 32'hC1);
    drive(1'b1, 8'hC2, 1'b1, 1'b1);
    step();
    chk("bp_beat3", 32'(out0_data), 32'hC2);
    chk("bp_last3", 32'(out0_last), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();

    // Independent drain: out1 stalled with a beat, out0 flows.
    out1_ready = 1'b0;
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h80 + i), i == 2, 1'b0);
      #1;
      chk("indep_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("indep_data0", 32'(out0_data), 32'(8'h80 + i));
      chk("indep_hold1", 32'(out1_data), 32'h77);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    out1_ready = 1'b1;
    step(); step();

    // Reset in the middle of a 4-beat packet headed to out0.
    out0_ready = 1'b0;
    drive(1'b1, 8'hE0, 1'b0, 1'b0);
    step();
    out0_ready = 1'b1;
    drive(1'b1, 8'hE1, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    chk("mid_rst_valid0", 32'(out0_valid), 32'd0);
    chk("mid_rst_cnt0", 32'(pkt_cnt0), 32'd0);
    drive(1'b1, 8'hF1, 1'b0, 1'b1);
    step();
    chk("post_rst_valid1", 32'(out1_valid), 32'd1);
    chk("post_rst_data1", 32'(out1_data), 32'hF1);
    chk("post_rst_valid0", 32'(out0_valid), 32'd0);
    drive(1'b1, 8'hF2, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0, 1'($urandom));
      out0_ready = $urandom_range(0, 3) != 0;
      out1_ready = $urandom_range(0, 2) != 0;
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    step(); step(); step();
    chk("drained0", 32'(q0.size()), 32'd0);
    chk("drained1", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
